// File: rtl/block_stream_pkg.sv
// Shared types and helpers for the block stream sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: 4-bit sequencer state enum, the state encodings as localparams,
// and chan_offset(), which gives the bit offset of pixel i of channel k in
// the flat core_pix vector.
package block_stream_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LOAD    = 4'd1;
    localparam logic [3:0] ST_PROCESS = 4'd2;
    localparam logic [3:0] ST_SAVE    = 4'd3;
    localparam logic [3:0] ST_DONE    = 4'd4;
    localparam logic [3:0] ST_ERR     = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_PROCESS = ST_PROCESS,
        S_SAVE    = ST_SAVE,
        S_DONE    = ST_DONE,
        S_ERR     = ST_ERR
    } state_t;

    // Channel k is one contiguous plane of depth pixels; pixel i sits at i*ch_w.
    function automatic int chan_offset(input int k, input int i,
                                       input int depth, input int ch_w);
        return k * depth * ch_w + i * ch_w;
    endfunction

endpackage

// File: rtl/block_result_buf.sv
// Result buffer: stores core result words in arrival order, counts them, flags overflow.
// Latency: write visible on the next cycle; read is combinational.
// Backpressure: none; words arriving while full are dropped and overflow is set.
//
// Ports: clk, rst (async, active-high); clr restarts count/overflow for a new
// block; wr/wr_data append a word; rd_addr/rd_data combinational read port;
// count = words stored; overflow = sticky until clr.
module block_result_buf
    import block_stream_pkg::*;
#(
    parameter int OUT_DEPTH = 64,
    parameter int WORD_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr,
    input  logic [WORD_W-1:0]            wr_data,
    input  logic [$clog2(OUT_DEPTH)-1:0] rd_addr,
    output logic [WORD_W-1:0]            rd_data,
    output logic [$clog2(OUT_DEPTH):0]   count,
    output logic                         overflow
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem [OUT_DEPTH];
    logic              full;

    assign full    = (count == CW'(OUT_DEPTH));
    assign rd_data = mem[rd_addr];

    // Storage is deliberately not reset; only count says what is valid.
    always_ff @(posedge clk) begin
        if (wr && !full) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_stream_sequencer.sv
// Block sequencer: load DEPTH packed words, hand unpacked pixels to the core, capture and replay results.
// Latency: PROCESS/core_start one cycle after the last load word; SAVE one cycle after core_finished.
// Backpressure: out_valid/out_ready on replay, 1 result/cycle; in_valid and core_valid cannot be stalled.
//
// Ports: clk, rst (async, active-high); start (level, rising edge in IDLE);
// in_valid/in_addr/in_data load port; core_start/core_pix to the core;
// core_valid/core_data/core_finished from the core; out_valid/out_ready/
// out_addr/out_data replay port; res_count, overflow, err, state_out status.
// Optional: define BLOCK_STREAM_SEQ_WATCHDOG_EN to add a TIMEOUT-cycle PROCESS
// watchdog that moves to ERR and raises err; without it err is tied low.
module block_stream_sequencer
    import block_stream_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int CH        = 3,
    parameter int CH_W      = 8,
    parameter int WORD_W    = 32,
    parameter int OUT_DEPTH = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [$clog2(DEPTH)-1:0]     in_addr,
    input  logic [WORD_W-1:0]            in_data,
    output logic                         core_start,
    output logic [CH*DEPTH*CH_W-1:0]     core_pix,
    input  logic                         core_valid,
    input  logic [WORD_W-1:0]            core_data,
    input  logic                         core_finished,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(OUT_DEPTH)-1:0] out_addr,
    output logic [WORD_W-1:0]            out_data,
    output logic [$clog2(OUT_DEPTH):0]   res_count,
    output logic                         overflow,
    output logic                         err,
    output logic [3:0]                   state_out
);
    localparam int IN_AW = $clog2(DEPTH);
    localparam int CW    = $clog2(OUT_DEPTH) + 1;
    localparam int PIX_W = CH * CH_W;

    state_t                   state;
    logic                     start_q;
    logic                     start_edge;
    logic                     clr;
    logic                     res_wr;
    logic [IN_AW-1:0]         load_cnt;
    logic [PIX_W-1:0]         in_buf [DEPTH];
    logic [PIX_W-1:0]         word;
    logic [CH*DEPTH*CH_W-1:0] pix_next;

    // Bits of in_data above the channel fields carry nothing for the core.
    logic unused_ok;
    assign unused_ok = ^in_data;

    assign start_edge = start && !start_q;
    assign clr        = (state == S_IDLE) && start_edge;
    assign res_wr     = (state == S_PROCESS) && core_valid;
    assign state_out  = state;

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            in_buf[in_addr] <= in_data[PIX_W-1:0];
        end
    end

    // Unpacked view of in_buf with this cycle's write folded in, so the
    // snapshot taken on the last load word already contains that word.
    always_comb begin
        pix_next = '0;
        word     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            word = in_buf[i];
            if (in_valid && in_addr == IN_AW'(i)) begin
                word = in_data[PIX_W-1:0];
            end
            for (int k = 0; k < CH; k++) begin
                pix_next[chan_offset(k, i, DEPTH, CH_W) +: CH_W] = word[k*CH_W +: CH_W];
            end
        end
    end

    block_result_buf #(
        .OUT_DEPTH (OUT_DEPTH),
        .WORD_W    (WORD_W)
    ) u_res_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr       (res_wr),
        .wr_data  (core_data),
        .rd_addr  (out_addr),
        .rd_data  (out_data),
        .count    (res_count),
        .overflow (overflow)
    );

`ifdef BLOCK_STREAM_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    assign err = err_q;
`else
    // TIMEOUT only matters when the watchdog is compiled in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            load_cnt   <= '0;
            core_start <= 1'b0;
            core_pix   <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
`ifdef BLOCK_STREAM_SEQ_WATCHDOG_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            start_q    <= start;
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state    <= S_LOAD;
                        load_cnt <= '0;
`ifdef BLOCK_STREAM_SEQ_WATCHDOG_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    // Duplicate addresses still count towards the block.
                    if (in_valid) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == IN_AW'(DEPTH - 1)) begin
                            state      <= S_PROCESS;
                            core_start <= 1'b1;
                            core_pix   <= pix_next;
`ifdef BLOCK_STREAM_SEQ_WATCHDOG_EN
                            wd_cnt     <= '0;
`endif
                        end
                    end
                end
                S_PROCESS: begin
                    // A result arriving with core_finished is stored this cycle,
                    // so it alone is enough to make the replay non-empty.
                    if (core_finished) begin
                        if (res_count != '0 || core_valid) begin
                            state     <= S_SAVE;
                            out_valid <= 1'b1;
                            out_addr  <= '0;
                        end else begin
                            state <= S_DONE;
                        end
                    end
`ifdef BLOCK_STREAM_SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        state <= S_ERR;
                        err_q <= 1'b1;
                    end
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                end
                S_SAVE: begin
                    if (out_ready) begin
                        out_addr <= out_addr + 1'b1;
                        if ({1'b0, out_addr} == res_count - 1'b1) begin
                            out_valid <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_stream_sequencer.sv
// Randomized self-checking bench for block_stream_sequencer against a queue/array model.
// Latency: n/a.
// Backpressure: exercises out_ready held high, a 1,0,0,1 pattern and random ready.
module tb_block_stream_sequencer;
    localparam int DEPTH     = 64;
    localparam int CH        = 3;
    localparam int CH_W      = 8;
    localparam int WORD_W    = 32;
    localparam int OUT_DEPTH = 64;
    localparam int TIMEOUT   = 16;
    localparam int IN_AW     = 6;
    localparam int OA        = 6;

    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_PROC = 2, ST_SAVE = 3, ST_DONE = 4, ST_ERR = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     in_valid;
    logic [IN_AW-1:0]         in_addr;
    logic [WORD_W-1:0]        in_data;
    logic                     core_start;
    logic [CH*DEPTH*CH_W-1:0] core_pix;
    logic                     core_valid;
    logic [WORD_W-1:0]        core_data;
    logic                     core_finished;
    logic                     out_valid;
    logic                     out_ready;
    logic [OA-1:0]            out_addr;
    logic [WORD_W-1:0]        out_data;
    logic [OA:0]              res_count;
    logic                     overflow;
    logic                     err;
    logic [3:0]               state_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0] model_in [DEPTH];
    logic [WORD_W-1:0] exp_q [$];

    block_stream_sequencer #(
        .DEPTH(DEPTH), .CH(CH), .CH_W(CH_W), .WORD_W(WORD_W),
        .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .core_start(core_start), .core_pix(core_pix),
        .core_valid(core_valid), .core_data(core_data), .core_finished(core_finished),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .res_count(res_count), .overflow(overflow), .err(err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pix();
        int bad;
        logic [CH_W-1:0] e;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < CH; k++) begin
                e = model_in[i][k*CH_W +: CH_W];
                if (core_pix[k*DEPTH*CH_W + i*CH_W +: CH_W] !== e) bad++;
            end
        end
        check("core_pix_bad_pixels", bad, 0);
    endtask

    // mode 0: ordered ramp words; mode 1: random addresses/data with idle gaps
    // carrying spurious core_valid pulses that must be ignored.
    task automatic do_load(input int mode);
        int cnt;
        int a;
        logic [WORD_W-1:0] d;
        cnt = 0;
        start = 1'b1;
        step();
        check("load_entry_state", state_out, ST_LOAD);
        while (cnt < DEPTH) begin
            if (mode == 1 && $urandom_range(3) == 0) begin
                in_valid   = 1'b0;
                core_valid = 1'b1;
                core_data  = $urandom;
            end else begin
                if (mode == 0) begin
                    a = cnt;
                    d = {8'h00, 8'(cnt + 2), 8'(cnt + 1), 8'(cnt)};
                end else begin
                    a = $urandom_range(DEPTH - 1);
                    d = $urandom;
                end
                in_valid    = 1'b1;
                in_addr     = IN_AW'(a);
                in_data     = d;
                model_in[a] = d;
                core_valid  = 1'b0;
                cnt++;
            end
            step();
        end
        in_valid   = 1'b0;
        core_valid = 1'b0;
        check("process_entry_state", state_out, ST_PROC);
        check("core_start_first", core_start, 1);
        check_pix();
    endtask

    task automatic do_core(input int n, input bit coincide);
        int sent;
        int exp_cnt;
        sent = 0;
        exp_q.delete();
        while (sent < n) begin
            core_finished = 1'b0;
            core_valid    = ($urandom_range(3) != 0);
            core_data     = $urandom;
            if (core_valid) begin
                if (sent < OUT_DEPTH) exp_q.push_back(core_data);
                sent++;
                if (sent == n && coincide) core_finished = 1'b1;
            end
            check("process_no_out_valid", out_valid, 0);
            step();
        end
        core_valid = 1'b0;
        if (!(coincide && n > 0)) begin
            core_finished = 1'b1;
            step();
        end
        core_finished = 1'b0;
        exp_cnt = (n < OUT_DEPTH) ? n : OUT_DEPTH;
        check("core_start_single", core_start, 0);
        check("res_count", res_count, exp_cnt);
        check("overflow", overflow, (n > OUT_DEPTH) ? 1 : 0);
        if (n > 0) begin
            check("save_entry_state", state_out, ST_SAVE);
            check("save_entry_valid", out_valid, 1);
            check("save_entry_addr", out_addr, 0);
        end else begin
            check("empty_done_state", state_out, ST_DONE);
            check("empty_no_valid", out_valid, 0);
        end
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0,1 repeating; mode 2: random ready.
    task automatic do_drain(input int mode);
        int idx;
        int cyc;
        bit rdy;
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 4 * OUT_DEPTH + 16) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(1));
            endcase
            out_ready = rdy;
            check("save_valid", out_valid, 1);
            check("save_addr", out_addr, idx);
            check("save_data", out_data, exp_q[idx]);
            step();
            cyc++;
            if (rdy) idx++;
        end
        out_ready = 1'b0;
        check("save_all_taken", idx, exp_q.size());
        if (mode == 0) check("save_cycles", cyc, exp_q.size());
        check("done_state", state_out, ST_DONE);
        check("done_no_valid", out_valid, 0);
    endtask

    task automatic finish_block(input int exp_cnt);
        start = 1'b0;
        step();
        check("idle_return", state_out, ST_IDLE);
        check("idle_res_count_held", res_count, exp_cnt);
        check("idle_err", err, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        core_valid = 1'b0; core_data = '0; core_finished = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_in[i] = '0;
        step();
        step();
        check("rst_state", state_out, ST_IDLE);
        check("rst_core_start", core_start, 0);
        check("rst_core_pix", |core_pix, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_res_count", res_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Block 1: ramp words, five results then a separate finished.
        do_load(0);
        check("pix_r3", core_pix[3*CH_W +: CH_W], 8'h03);
        check("pix_g3", core_pix[DEPTH*CH_W + 3*CH_W +: CH_W], 8'h04);
        check("pix_b63", core_pix[2*DEPTH*CH_W + 63*CH_W +: CH_W], 8'd65);
        do_core(5, 1'b0);
        do_drain(0);
        finish_block(5);

        // Block 2: random loads, finished with the last word, stalling ready.
        do_load(1);
        do_core(7, 1'b1);
        do_drain(1);
        finish_block(7);

        // Block 3: core overruns the result buffer.
        do_load(1);
        do_core(OUT_DEPTH + 3, 1'b0);
        do_drain(0);
        finish_block(OUT_DEPTH);

        // Block 4: no results at all; DONE holds while start stays high.
        do_load(1);
        do_core(0, 1'b0);
        step();
        check("done_hold", state_out, ST_DONE);
        check("done_hold_no_valid", out_valid, 0);
        finish_block(0);

        // Reset in the middle of a load, then a clean block.
        start = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_addr  = IN_AW'(i);
            in_data  = $urandom;
            model_in[i] = in_data;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("midrst_state", state_out, ST_IDLE);
        check("midrst_core_pix", |core_pix, 0);
        check("midrst_core_start", core_start, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_addr", out_addr, 0);
        check("midrst_res_count", res_count, 0);
        check("midrst_overflow", overflow, 0);
        step();
        rst = 1'b0;
        step();
        check("postrst_idle", state_out, ST_IDLE);
        do_load(1);
        do_core(3, 1'b1);
        do_drain(2);
        finish_block(3);

`ifdef BLOCK_STREAM_SEQ_WATCHDOG_EN
        begin
            int n;
            do_load(1);
            n = 1;
            while (state_out == 4'(ST_PROC) && n < 100) begin
                step();
                if (state_out == 4'(ST_PROC)) n++;
            end
            check("wd_process_cycles", n, TIMEOUT);
            check("wd_err_state", state_out, ST_ERR);
            check("wd_err_flag", err, 1);
            check("wd_no_valid", out_valid, 0);
            start = 1'b0;
            step();
            check("wd_idle", state_out, ST_IDLE);
            check("wd_err_sticky", err, 1);
            start = 1'b1;
            step();
            check("wd_err_cleared", err, 0);
            check("wd_reload", state_out, ST_LOAD);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/block_stream_sequencer.md
# block_stream_sequencer

Parametrised successor of the single-block user function: collects one block of DEPTH packed pixel words from the AXI register side, unpacks CH channels into flat vectors for a processing core, captures a variable-length result stream from that core into a result buffer, then replays the results to the AXI side under a valid/ready handshake. It sits between the AXI register-file logic and the image-compression core wrapper.

## Interface
- DEPTH, 64, words per input block (power of two, ≥4)
- CH, 3, channels unpacked per word (CH*CH_W ≤ WORD_W)
- CH_W, 8, bits per channel; channel k = word[k*CH_W +: CH_W]
- WORD_W, 32, input/result word width
- OUT_DEPTH, 64, result buffer entries
- TIMEOUT, 4096, PROCESS watchdog limit in cycles (used only with the macro)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; rising edge seen in IDLE starts a block
- in_valid  in  1  in_addr/in_data are valid this cycle
- in_addr  in  $clog2(DEPTH)  input word index
- in_data  in  WORD_W  packed pixel word
- core_start  out  1  one-cycle start pulse to the core
- core_pix  out  CH*DEPTH*CH_W  channel k occupies [k*DEPTH*CH_W +: DEPTH*CH_W]; pixel i at offset i*CH_W
- core_valid  in  1  core_data valid
- core_data  in  WORD_W  result word
- core_finished  in  1  core done (may coincide with core_valid)
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  downstream accepts
- out_addr  out  $clog2(OUT_DEPTH)  result index
- out_data  out  WORD_W  result_buf[out_addr], combinational read
- res_count  out  $clog2(OUT_DEPTH)+1  results captured this block
- overflow  out  1  sticky per block: core produced more than OUT_DEPTH words
- err  out  1  watchdog expired (macro only, else tied 0)
- state_out  out  4  current state encoding

## Operation
- States (encoding): IDLE=0, LOAD=1, PROCESS=2, SAVE=3, DONE=4, ERR=5.
- IDLE: start_q registered each cycle; start && !start_q → LOAD; clears load_cnt, res_count, overflow, err. Start edges in any other state ignored.
- LOAD: each in_valid cycle writes in_buf[in_addr] and increments load_cnt. When in_valid && load_cnt==DEPTH-1 → PROCESS. Duplicate addresses still count; unwritten entries keep prior contents.
- PROCESS: core_pix registered from in_buf on the LOAD→PROCESS edge, held stable until next LOAD exit. core_start high exactly on first PROCESS cycle. Each core_valid writes result_buf[res_count] and increments res_count while res_count<OUT_DEPTH; further words dropped and overflow set. core_finished → SAVE (if res_count after that cycle's write >0) else → DONE.
- SAVE: out_valid=1, out_addr starts 0; on out_valid&&out_ready out_addr increments; transfer of index res_count-1 → DONE. out_ready low holds addr/data stable.
- DONE/ERR: hold while start high; start low → IDLE.
- Outputs held while idle; core_valid outside PROCESS ignored.

## Timing
- Reset: state IDLE, core_start=0, core_pix=0, out_valid=0, out_addr=0, res_count=0, overflow=0, err=0, state_out=0; buffers not reset.
- start edge at cycle t → state_out=1 at t+1.
- Last load word at t → PROCESS and core_start at t+1, core_pix valid at t+1.
- core_finished at t → SAVE at t+1, out_valid at t+1 with out_addr=0.
- Throughput 1 result/cycle with out_ready held high; N results leave in N cycles, DONE the cycle after the last handshake.
- Reset asserted in any state returns to IDLE immediately; no partial output continues.

## Configuration
- BLOCK_STREAM_SEQ_WATCHDOG_EN defined: cycle counter in PROCESS; reaching TIMEOUT without core_finished → ERR, err=1 until next IDLE start edge; results discarded.
- Undefined: no counter, PROCESS waits indefinitely, err tied 0, ERR unreachable.

## Structure
- block_stream_pkg: state enum (4-bit), state encodings as localparams, helper function for channel slice offsets.
- One sub-module: block_result_buf (OUT_DEPTH×WORD_W write port, combinational read, count and overflow logic).

## Test plan
- Load words i→{8'h0,B=i+2,G=i+1,R=i}, core returns 5 words then finished → core_pix R pixel 3 = 8'h03, out_data sequence matches, res_count=5, DONE.
- out_ready toggling 1,0,0,1 during SAVE → out_addr/out_data stable while low, no loss or duplicates.
- Core emits OUT_DEPTH+3 words → first OUT_DEPTH stored, overflow=1, res_count=OUT_DEPTH.
- core_finished with zero results → PROCESS→DONE directly, out_valid never high.
- rst pulsed mid-LOAD (word 20) → IDLE next edge, all outputs at reset values, fresh block loads correctly.
- Watchdog build, core silent, TIMEOUT=16 → ERR after 16 PROCESS cycles, err=1; start low → IDLE.
